// File: rtl/pipeline_pkg.sv
// Shared pipeline widths, reset/bubble constants and the fetch-stage control types.
package pipeline_pkg;

    localparam int INSTR_W   = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 16384;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
    localparam logic [ADDR_W-1:0]  RESET_PC  = '0;

    // RUN fetches normally; HALT is entered on an illegal fetch address and left only by reset.
    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    // What the IF/ID register does on the next edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_ctl_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus plus the IF/ID register outputs of the fetch stage.
interface fetch_stage_if
    import pipeline_pkg::*;
();

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc4;
    logic               ifid_valid;

    // Fetch stage side: drives the address and the IF/ID contents.
    modport master (
        output imem_addr,
        input  imem_instr,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid
    );

    // Memory / decode side.
    modport slave (
        input  imem_addr,
        output imem_instr,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid
    );

endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register with hold / bubble / load control and the fetch counter.
module fetch_ifid_reg
    import pipeline_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  ifid_ctl_e          ctl,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc4,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               ifid_valid,
    output logic [31:0]        fetch_count
);

    // Register update: bubbles leave the counter alone, only real captures count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr  <= NOP_INSTR;
            ifid_pc4    <= '0;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else begin
            unique case (ctl)
                IFID_BUBBLE: begin
                    ifid_instr <= NOP_INSTR;
                    ifid_pc4   <= '0;
                    ifid_valid <= 1'b0;
                end
                IFID_LOAD: begin
                    ifid_instr  <= load_instr;
                    ifid_pc4    <= load_pc4;
                    ifid_valid  <= 1'b1;
                    fetch_count <= fetch_count + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch-address legality check and redirect priority.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = pipeline_pkg::RESET_PC,
    parameter int                 MEM_BYTES = pipeline_pkg::MEM_BYTES,
    parameter logic [INSTR_W-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_jump_target,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    fetch_stage_if.master     bus,
    output logic              fetch_fault,
    output logic [31:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic              legal;
    fetch_state_e      state;
    fetch_state_e      state_next;
    ifid_ctl_e         ifid_ctl;

    assign bus.imem_addr = pc;
    assign pc_plus4      = pc + 32'd4;
    assign legal         = (pc[1:0] == 2'b00) && (pc <= LAST_WORD);
    assign fetch_fault   = (state == FS_HALT);

    // PC and run/halt state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= FS_RUN;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    // Fixed-priority next-PC / IF/ID control: halt, branch, jump, illegal, stall, sequential.
    always_comb begin
        pc_next    = pc;
        state_next = state;
        ifid_ctl   = IFID_HOLD;
        if (state == FS_HALT) begin
            ifid_ctl = IFID_BUBBLE;
        end else if (ex_branch_taken) begin
            pc_next  = ex_branch_target;
            ifid_ctl = IFID_BUBBLE;
        end else if (id_jump) begin
            pc_next  = id_jump_target;
            ifid_ctl = IFID_BUBBLE;
        end else if (!legal) begin
            state_next = FS_HALT;
            ifid_ctl   = IFID_BUBBLE;
        end else if (stall) begin
            ifid_ctl = IFID_HOLD;
        end else begin
            pc_next  = pc_plus4;
            ifid_ctl = IFID_LOAD;
        end
    end

    fetch_ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .ctl        (ifid_ctl),
        .load_instr (bus.imem_instr),
        .load_pc4   (pc_plus4),
        .ifid_instr (bus.ifid_instr),
        .ifid_pc4   (bus.ifid_pc4),
        .ifid_valid (bus.ifid_valid),
        .fetch_count(fetch_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a byte-array big-endian instruction memory.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int vectors;
    int miscompares;

    logic [7:0] mem [0:16383];

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(16384),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_jump         (id_jump),
        .id_jump_target  (id_jump_target),
        .ex_branch_taken (ex_branch_taken),
        .ex_branch_target(ex_branch_target),
        .bus             (bus),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        int i;
        if (a > 32'd16380) return 32'hDEAD_BEEF;
        i = int'(a);
        return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
    endfunction

    // Combinational, zero-latency read.
    always_comb bus.imem_instr = rd(bus.imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; id_jump = 1'b0; id_jump_target = '0;
        ex_branch_taken = 1'b0; ex_branch_target = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step(); step();
        vectors++; if (bus.imem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_pc got %h want %h", bus.imem_addr, 32'd0); end
        vectors++; if (bus.ifid_instr !== 32'd0) begin miscompares++; $display("FAIL reset_instr got %h want %h", bus.ifid_instr, 32'd0); end
        vectors++; if (bus.ifid_pc4 !== 32'd0) begin miscompares++; $display("FAIL reset_pc4 got %h want %h", bus.ifid_pc4, 32'd0); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.ifid_valid); end
        vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", fetch_fault); end
        vectors++; if (fetch_count !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        vectors++; if (bus.imem_instr !== 32'h4940_0000) begin miscompares++; $display("FAIL seq_imem0 got %h want %h", bus.imem_instr, 32'h4940_0000); end
        step();
        vectors++; if (bus.imem_addr !== 32'd4) begin miscompares++; $display("FAIL seq_addr1 got %0d want 4", bus.imem_addr); end
        vectors++; if (bus.ifid_instr !== 32'h4940_0000) begin miscompares++; $display("FAIL seq_instr1 got %h want %h", bus.ifid_instr, 32'h4940_0000); end
        vectors++; if (bus.ifid_pc4 !== 32'd4) begin miscompares++; $display("FAIL seq_pc4_1 got %0d want 4", bus.ifid_pc4); end
        vectors++; if (bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL seq_valid1 got %b want 1", bus.ifid_valid); end
        step();
        vectors++; if (bus.imem_addr !== 32'd8) begin miscompares++; $display("FAIL seq_addr2 got %0d want 8", bus.imem_addr); end
        vectors++; if (bus.ifid_instr !== 32'h4941_0004) begin miscompares++; $display("FAIL seq_instr2 got %h want %h", bus.ifid_instr, 32'h4941_0004); end
        vectors++; if (bus.ifid_pc4 !== 32'd8) begin miscompares++; $display("FAIL seq_pc4_2 got %0d want 8", bus.ifid_pc4); end
        vectors++; if (fetch_count !== 32'd2) begin miscompares++; $display("FAIL seq_count2 got %0d want 2", fetch_count); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (bus.imem_addr !== 32'd8) begin miscompares++; $display("FAIL stall_addr[%0d] got %0d want 8", i, bus.imem_addr); end
            vectors++; if (bus.ifid_instr !== 32'h4941_0004) begin miscompares++; $display("FAIL stall_instr[%0d] got %h want %h", i, bus.ifid_instr, 32'h4941_0004); end
            vectors++; if (bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus.ifid_valid); end
            vectors++; if (fetch_count !== 32'd2) begin miscompares++; $display("FAIL stall_count[%0d] got %0d want 2", i, fetch_count); end
        end
        stall = 1'b0;
        step();
        vectors++; if (bus.ifid_instr !== 32'h4942_0008) begin miscompares++; $display("FAIL unstall_instr got %h want %h", bus.ifid_instr, 32'h4942_0008); end
        vectors++; if (bus.ifid_pc4 !== 32'd12) begin miscompares++; $display("FAIL unstall_pc4 got %0d want 12", bus.ifid_pc4); end
        vectors++; if (fetch_count !== 32'd3) begin miscompares++; $display("FAIL unstall_count got %0d want 3", fetch_count); end
        vectors++; if (bus.imem_addr !== 32'd12) begin miscompares++; $display("FAIL unstall_addr got %0d want 12", bus.imem_addr); end
    endtask

    task automatic test_jump();
        id_jump = 1'b1; id_jump_target = 32'd100; stall = 1'b1;
        step();
        clear_inputs();
        vectors++; if (bus.imem_addr !== 32'd100) begin miscompares++; $display("FAIL jump_addr got %0d want 100", bus.imem_addr); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL jump_valid got %b want 0", bus.ifid_valid); end
        vectors++; if (bus.ifid_instr !== 32'd0) begin miscompares++; $display("FAIL jump_instr got %h want 0", bus.ifid_instr); end
        vectors++; if (bus.ifid_pc4 !== 32'd0) begin miscompares++; $display("FAIL jump_pc4 got %0d want 0", bus.ifid_pc4); end
        vectors++; if (fetch_count !== 32'd3) begin miscompares++; $display("FAIL jump_count got %0d want 3", fetch_count); end
        step();
        vectors++; if (bus.ifid_instr !== 32'h2400_0005) begin miscompares++; $display("FAIL jump_next_instr got %h want %h", bus.ifid_instr, 32'h2400_0005); end
        vectors++; if (bus.ifid_pc4 !== 32'd104) begin miscompares++; $display("FAIL jump_next_pc4 got %0d want 104", bus.ifid_pc4); end
        vectors++; if (fetch_count !== 32'd4) begin miscompares++; $display("FAIL jump_next_count got %0d want 4", fetch_count); end
    endtask

    task automatic test_branch_priority();
        ex_branch_taken = 1'b1; ex_branch_target = 32'd400;
        id_jump = 1'b1; id_jump_target = 32'd500; stall = 1'b1;
        step();
        clear_inputs();
        vectors++; if (bus.imem_addr !== 32'd400) begin miscompares++; $display("FAIL br_addr got %0d want 400", bus.imem_addr); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL br_valid got %b want 0", bus.ifid_valid); end
        step();
        vectors++; if (bus.ifid_instr !== 32'h2653_0000) begin miscompares++; $display("FAIL br_next_instr got %h want %h", bus.ifid_instr, 32'h2653_0000); end
        vectors++; if (bus.ifid_pc4 !== 32'd404) begin miscompares++; $display("FAIL br_next_pc4 got %0d want 404", bus.ifid_pc4); end
        vectors++; if (fetch_count !== 32'd5) begin miscompares++; $display("FAIL br_next_count got %0d want 5", fetch_count); end
    endtask

    task automatic test_fault_range();
        ex_branch_taken = 1'b1; ex_branch_target = 32'd16384;
        step();
        clear_inputs();
        vectors++; if (bus.imem_addr !== 32'd16384) begin miscompares++; $display("FAIL rng_addr got %0d want 16384", bus.imem_addr); end
        vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL rng_fault_early got %b want 0", fetch_fault); end
        step();
        vectors++; if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL rng_fault got %b want 1", fetch_fault); end
        vectors++; if (bus.imem_addr !== 32'd16384) begin miscompares++; $display("FAIL rng_hold got %0d want 16384", bus.imem_addr); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL rng_valid got %b want 0", bus.ifid_valid); end
        vectors++; if (fetch_count !== 32'd5) begin miscompares++; $display("FAIL rng_count got %0d want 5", fetch_count); end
        id_jump = 1'b1; id_jump_target = 32'd0;
        step();
        ex_branch_taken = 1'b1; ex_branch_target = 32'd8;
        step();
        vectors++; if (bus.imem_addr !== 32'd16384) begin miscompares++; $display("FAIL halt_ignore_addr got %0d want 16384", bus.imem_addr); end
        vectors++; if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL halt_sticky got %b want 1", fetch_fault); end
        // Reset wins even with redirects still asserted.
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        vectors++; if (bus.imem_addr !== 32'd0) begin miscompares++; $display("FAIL rst_addr got %0d want 0", bus.imem_addr); end
        vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault got %b want 0", fetch_fault); end
        vectors++; if (fetch_count !== 32'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", fetch_count); end
    endtask

    task automatic test_misaligned();
        step();
        vectors++; if (fetch_count !== 32'd1) begin miscompares++; $display("FAIL mis_pre_count got %0d want 1", fetch_count); end
        id_jump = 1'b1; id_jump_target = 32'd102;
        step();
        clear_inputs();
        vectors++; if (bus.imem_addr !== 32'd102) begin miscompares++; $display("FAIL mis_addr got %0d want 102", bus.imem_addr); end
        vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL mis_fault_early got %b want 0", fetch_fault); end
        step();
        vectors++; if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL mis_fault got %b want 1", fetch_fault); end
        vectors++; if (bus.ifid_instr !== 32'd0) begin miscompares++; $display("FAIL mis_nocapture got %h want 0", bus.ifid_instr); end
        vectors++; if (bus.ifid_valid !== 1'b0) begin miscompares++; $display("FAIL mis_valid got %b want 0", bus.ifid_valid); end
        vectors++; if (bus.imem_addr !== 32'd102) begin miscompares++; $display("FAIL mis_hold got %0d want 102", bus.imem_addr); end
        vectors++; if (fetch_count !== 32'd1) begin miscompares++; $display("FAIL mis_count got %0d want 1", fetch_count); end
    endtask

    task automatic test_last_word();
        rst = 1'b1;
        step();
        rst = 1'b0;
        id_jump = 1'b1; id_jump_target = 32'd16380;
        step();
        clear_inputs();
        step();
        vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL last_fault got %b want 0", fetch_fault); end
        vectors++; if (bus.ifid_instr !== 32'hAABB_CCDD) begin miscompares++; $display("FAIL last_instr got %h want %h", bus.ifid_instr, 32'hAABB_CCDD); end
        vectors++; if (bus.ifid_pc4 !== 32'd16384) begin miscompares++; $display("FAIL last_pc4 got %0d want 16384", bus.ifid_pc4); end
        vectors++; if (bus.ifid_valid !== 1'b1) begin miscompares++; $display("FAIL last_valid got %b want 1", bus.ifid_valid); end
        vectors++; if (fetch_count !== 32'd1) begin miscompares++; $display("FAIL last_count got %0d want 1", fetch_count); end
        step();
        vectors++; if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL past_end_fault got %b want 1", fetch_fault); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        {mem[0], mem[1], mem[2], mem[3]}         = 32'h4940_0000;
        {mem[4], mem[5], mem[6], mem[7]}         = 32'h4941_0004;
        {mem[8], mem[9], mem[10], mem[11]}       = 32'h4942_0008;
        {mem[12], mem[13], mem[14], mem[15]}     = 32'h1111_2222;
        {mem[100], mem[101], mem[102], mem[103]} = 32'h2400_0005;
        {mem[104], mem[105], mem[106], mem[107]} = 32'h3333_4444;
        {mem[400], mem[401], mem[402], mem[403]} = 32'h2653_0000;
        {mem[16380], mem[16381], mem[16382], mem[16383]} = 32'hAABB_CCDD;

        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_branch_priority();
        test_fault_range();
        test_misaligned();
        test_last_word();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
